// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC stage feeding the PC adder and sequencing imem req/ack fetches; PC_FETCH_CNT_EN adds fetch_cnt_o.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                STEP     = 4,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] step_o,
    input  logic [ADDR_W-1:0] sum_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              fault_o
`ifdef PC_FETCH_CNT_EN
    ,
    output logic [31:0]       fetch_cnt_o
`endif
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    typedef enum logic [1:0] {BOOT, REQ, STALL, FAULT} state_t;
    state_t            state, state_nx;
    logic [CW-1:0]     wait_cnt, wait_nx;
    logic [ADDR_W-1:0] pc_nx, pend_pc, pend_nx, inst_pc_nx, tgt;
    logic              pend_v, pend_v_nx, valid_nx, redir;
    assign redir       = jump_i | branch_taken_i;
    assign tgt         = jump_i ? jump_target_i : branch_target_i;
    assign step_o      = ADDR_W'(STEP);
    assign imem_req_o  = state == REQ;
    assign imem_addr_o = pc_o;
    assign fault_o     = state == FAULT;
    always_comb begin
        state_nx   = state;
        pc_nx      = pc_o;
        pend_v_nx  = pend_v;
        pend_nx    = pend_pc;
        wait_nx    = wait_cnt;
        valid_nx   = 1'b0;
        inst_pc_nx = inst_pc_o;
        case (state)
            BOOT: state_nx = REQ;
            REQ: begin
                if (imem_ack_i) begin
                    // a redirect seen now or while waiting squashes this fetch
                    valid_nx   = !redir && !pend_v;
                    inst_pc_nx = valid_nx ? pc_o : inst_pc_o;
                    pc_nx      = redir ? tgt : pend_v ? pend_pc : sum_i;
                    pend_v_nx  = 1'b0;
                    wait_nx    = '0;
                    state_nx   = stall_i ? STALL : REQ;
                end else begin
                    pend_v_nx = pend_v | redir;
                    pend_nx   = redir ? tgt : pend_pc;
                    wait_nx   = wait_cnt + 1'b1;
                    state_nx  = (wait_cnt == CW'(MAX_WAIT - 1)) ? FAULT : REQ;
                end
            end
            STALL: begin
                pc_nx    = redir ? tgt : pc_o;
                wait_nx  = '0;
                state_nx = stall_i ? STALL : REQ;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= BOOT;
            pc_o         <= RESET_PC;
            pend_v       <= 1'b0;
            pend_pc      <= '0;
            wait_cnt     <= '0;
            inst_valid_o <= 1'b0;
            inst_pc_o    <= '0;
        end else begin
            state        <= state_nx;
            pc_o         <= pc_nx;
            pend_v       <= pend_v_nx;
            pend_pc      <= pend_nx;
            wait_cnt     <= wait_nx;
            inst_valid_o <= valid_nx;
            inst_pc_o    <= inst_pc_nx;
        end
    end
`ifdef PC_FETCH_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) fetch_cnt_o <= '0;
        else        fetch_cnt_o <= fetch_cnt_o + 32'(valid_nx);
    end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed and randomized checks of pc_fetch_unit against a transaction-level model.
module tb_pc_fetch_unit;
    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic        rst_i, stall_i, branch_taken_i, jump_i, imem_ack_i;
    logic [31:0] branch_target_i, jump_target_i, sum_i, sum_w;
    logic [31:0] pc_o, pc_w, step_o, step_w, imem_addr_o, addr_w, inst_pc_o, inst_pc_w;
    logic        imem_req_o, req_w, inst_valid_o, valid_w, fault_o, fault_w;
`ifdef PC_FETCH_CNT_EN
    logic [31:0] fetch_cnt_o, cnt_w;
`endif
    int n_chk = 0, n_fail = 0;
    logic [31:0] m_pc, m_pend, m_ipc, m_cnt;
    bit          m_boot, m_stall, m_fault, m_pv, m_valid;
    int          m_wait;

    assign sum_i = pc_o + 32'd4;
    assign sum_w = pc_w + 32'd4;

    pc_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .pc_o(pc_o), .step_o(step_o), .sum_i(sum_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ack_i(imem_ack_i),
        .inst_valid_o(inst_valid_o), .inst_pc_o(inst_pc_o), .fault_o(fault_o)
`ifdef PC_FETCH_CNT_EN
        , .fetch_cnt_o(fetch_cnt_o)
`endif
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .jump_i(jump_i), .jump_target_i(jump_target_i),
        .pc_o(pc_w), .step_o(step_w), .sum_i(sum_w),
        .imem_req_o(req_w), .imem_addr_o(addr_w), .imem_ack_i(imem_ack_i),
        .inst_valid_o(valid_w), .inst_pc_o(inst_pc_w), .fault_o(fault_w)
`ifdef PC_FETCH_CNT_EN
        , .fetch_cnt_o(cnt_w)
`endif
    );

    task automatic model_reset;
        m_pc = 32'h0; m_pend = 32'h0; m_ipc = 32'h0; m_cnt = 32'h0;
        m_boot = 1; m_stall = 0; m_fault = 0; m_pv = 0; m_valid = 0; m_wait = 0;
    endtask

    task automatic do_reset;
        rst_i = 1'b0; stall_i = 0; branch_taken_i = 0; jump_i = 0; imem_ack_i = 0;
        branch_target_i = 0; jump_target_i = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
    endtask

    // drive one cycle of inputs, advance a clock and update the reference model
    task automatic tick(input bit a, input bit s, input bit jv, input logic [31:0] jtv,
                        input bit bv, input logic [31:0] btv);
        bit          rd;
        logic [31:0] tg;
        imem_ack_i = a; stall_i = s; jump_i = jv; jump_target_i = jtv;
        branch_taken_i = bv; branch_target_i = btv;
        @(posedge clk_i);
        rd = jv | bv;
        tg = jv ? jtv : btv;
        m_valid = 0;
        if (m_boot) m_boot = 0;
        else if (m_fault) begin end
        else if (m_stall) begin
            if (rd) m_pc = tg;
            m_stall = s;
            m_wait = 0;
        end else if (a) begin
            m_valid = !rd && !m_pv;
            if (m_valid) begin m_ipc = m_pc; m_cnt = m_cnt + 1; end
            m_pc = rd ? tg : (m_pv ? m_pend : m_pc + 32'd4);
            m_pv = 0;
            m_stall = s;
            m_wait = 0;
        end else begin
            if (rd) begin m_pv = 1; m_pend = tg; end
            m_wait++;
            m_fault = (m_wait == 15);
        end
        #1;
    endtask

    task automatic test_reset;
        do_reset();
        n_chk++; if (pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc_o, 32'h0); end
        n_chk++; if (pc_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL reset_pc_w got %h want %h", pc_w, 32'hFFFF_FFFC); end
        n_chk++; if (imem_req_o !== 1'b0 || req_w !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req_o); end
        n_chk++; if (inst_valid_o !== 1'b0 || inst_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_valid got %b/%h want 0/0", inst_valid_o, inst_pc_o); end
        n_chk++; if (fault_o !== 1'b0 || fault_w !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault_o); end
        n_chk++; if (step_o !== 32'd4 || step_w !== 32'd4) begin n_fail++; $display("FAIL step got %h want 4", step_o); end
    endtask

    task automatic test_sequential;
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL seq_first_req got %b/%h want 1/0", imem_req_o, imem_addr_o); end
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0, 0, 0);
            n_chk++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_valid%0d got %b/%h want 1/%h", i, inst_valid_o, inst_pc_o, 32'(4 * i)); end
            n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_addr%0d got %b/%h want 1/%h", i, imem_req_o, imem_addr_o, 32'(4 * i + 4)); end
        end
`ifdef PC_FETCH_CNT_EN
        n_chk++; if (fetch_cnt_o !== 32'd3) begin n_fail++; $display("FAIL seq_cnt got %0d want 3", fetch_cnt_o); end
`endif
    endtask

    task automatic test_redirect;
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 1, 32'h100, 1, 32'h200);
        n_chk++; if (pc_o !== 32'h100 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL jump_ack got %h/%b want 100/0", pc_o, inst_valid_o); end
        tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h100) begin n_fail++; $display("FAIL jump_fetch got %b/%h want 1/100", inst_valid_o, inst_pc_o); end
        tick(0, 0, 0, 0, 1, 32'h40);
        n_chk++; if (pc_o !== 32'h104 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL pend_hold got %h/%b want 104/1", pc_o, imem_req_o); end
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (pc_o !== 32'h40 || inst_valid_o !== 1'b0 || imem_addr_o !== 32'h40) begin n_fail++; $display("FAIL pend_ack got %h/%b/%h want 40/0/40", pc_o, inst_valid_o, imem_addr_o); end
        tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (inst_valid_o !== 1'b1 || inst_pc_o !== 32'h40) begin n_fail++; $display("FAIL pend_next got %b/%h want 1/40", inst_valid_o, inst_pc_o); end
        tick(0, 0, 0, 0, 1, 32'h80);
        tick(0, 0, 1, 32'h90, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (pc_o !== 32'h90 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL pend_overwrite got %h/%b want 90/0", pc_o, inst_valid_o); end
    endtask

    task automatic test_stall;
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL stall_pre got %h want 8", imem_addr_o); end
        tick(1, 1, 0, 0, 0, 0);
        n_chk++; if (pc_o !== 32'hC || imem_req_o !== 1'b0 || inst_valid_o !== 1'b1 || inst_pc_o !== 32'h8) begin n_fail++; $display("FAIL stall_enter got %h/%b/%b/%h want c/0/1/8", pc_o, imem_req_o, inst_valid_o, inst_pc_o); end
        tick(1, 1, 0, 0, 0, 0);
        n_chk++; if (pc_o !== 32'hC || imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL stall_ack_ignored got %h/%b/%b want c/0/0", pc_o, imem_req_o, inst_valid_o); end
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'hC) begin n_fail++; $display("FAIL stall_resume got %b/%h want 1/c", imem_req_o, imem_addr_o); end
        tick(1, 1, 0, 0, 0, 0);
        tick(0, 1, 1, 32'h300, 0, 0);
        n_chk++; if (pc_o !== 32'h300 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL stall_jump got %h/%b want 300/0", pc_o, imem_req_o); end
        tick(0, 0, 0, 0, 0, 0);
        n_chk++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin n_fail++; $display("FAIL stall_jump_req got %b/%h want 1/300", imem_req_o, imem_addr_o); end
    endtask

    task automatic test_timeout;
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        repeat (14) tick(0, 0, 0, 0, 0, 0);
        n_chk++; if (fault_o !== 1'b0 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL timeout_early got %b/%b want 0/1", fault_o, imem_req_o); end
        tick(0, 0, 0, 0, 0, 0);
        n_chk++; if (fault_o !== 1'b1 || imem_req_o !== 1'b0) begin n_fail++; $display("FAIL timeout_hit got %b/%b want 1/0", fault_o, imem_req_o); end
        repeat (3) tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (fault_o !== 1'b1 || imem_req_o !== 1'b0 || inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL timeout_sticky got %b/%b/%b want 1/0/0", fault_o, imem_req_o, inst_valid_o); end
        do_reset();
        n_chk++; if (fault_o !== 1'b0) begin n_fail++; $display("FAIL timeout_clear got %b want 0", fault_o); end
    endtask

    task automatic test_wrap_and_async_reset;
        do_reset();
        tick(0, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        n_chk++; if (pc_w !== 32'h0 || inst_pc_w !== 32'hFFFF_FFFC || valid_w !== 1'b1) begin n_fail++; $display("FAIL wrap got %h/%h/%b want 0/fffffffc/1", pc_w, inst_pc_w, valid_w); end
        n_chk++; if (pc_o !== 32'h4) begin n_fail++; $display("FAIL wrap_ref got %h want 4", pc_o); end
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        #1;
        n_chk++; if (pc_o !== 32'h0 || pc_w !== 32'hFFFF_FFFC || imem_req_o !== 1'b0 || addr_w !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL async_reset got %h/%h/%b want 0/fffffffc/0", pc_o, pc_w, imem_req_o); end
        imem_ack_i = 1'b1;
        @(posedge clk_i); #1;
        n_chk++; if (inst_valid_o !== 1'b0 || valid_w !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b want 0", inst_valid_o); end
        imem_ack_i = 1'b0;
`ifdef PC_FETCH_CNT_EN
        n_chk++; if (cnt_w !== 32'd0) begin n_fail++; $display("FAIL abort_cnt got %0d want 0", cnt_w); end
`endif
    endtask

    task automatic test_random;
        bit a, s, jv, bv;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            n_chk++; if (imem_req_o !== (!m_boot && !m_stall && !m_fault)) begin n_fail++; $display("FAIL rnd_req c%0d got %b want %b", c, imem_req_o, !m_boot && !m_stall && !m_fault); end
            n_chk++; if (pc_o !== m_pc || imem_addr_o !== m_pc) begin n_fail++; $display("FAIL rnd_pc c%0d got %h/%h want %h", c, pc_o, imem_addr_o, m_pc); end
            n_chk++; if (inst_valid_o !== m_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b want %b", c, inst_valid_o, m_valid); end
            if (m_valid) begin
                n_chk++; if (inst_pc_o !== m_ipc) begin n_fail++; $display("FAIL rnd_inst_pc c%0d got %h want %h", c, inst_pc_o, m_ipc); end
            end
            n_chk++; if (fault_o !== m_fault) begin n_fail++; $display("FAIL rnd_fault c%0d got %b want %b", c, fault_o, m_fault); end
            a  = ($urandom_range(0, 2) == 0) || (m_wait >= 12);
            s  = $urandom_range(0, 3) == 0;
            jv = $urandom_range(0, 7) == 0;
            bv = $urandom_range(0, 7) == 0;
            tick(a, s, jv, $urandom & 32'hFFFF_FFFC, bv, $urandom & 32'hFFFF_FFFC);
        end
`ifdef PC_FETCH_CNT_EN
        n_chk++; if (fetch_cnt_o !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt got %0d want %0d", fetch_cnt_o, m_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect();
        test_stall();
        test_timeout();
        test_wrap_and_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter stage directly upstream of the 32-bit PC adder.
- Holds the current PC and drives it plus a constant step into the adder.
- Takes the adder sum back as the sequential next PC; applies branch/jump redirects.
- Sequences instruction-memory fetches with a req/ack handshake and emits fetched-PC valid pulses to decode.

Parameters:
- ADDR_W, 32, PC/address width; must match adder width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- STEP, 4, byte increment driven on step_o.
- MAX_WAIT, 15, max cycles imem_req_o may stay unacknowledged before fault.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- stall_i  in  1  downstream stall; hold PC and withhold new requests.
- branch_taken_i  in  1  branch redirect request, sampled each cycle.
- branch_target_i  in  ADDR_W  branch target.
- jump_i  in  1  jump redirect request; priority over branch.
- jump_target_i  in  ADDR_W  jump target.
- pc_o  out  ADDR_W  current PC; to adder src1.
- step_o  out  ADDR_W  constant STEP; to adder src2.
- sum_i  in  ADDR_W  adder sum (pc_o+step_o, combinational, same cycle).
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  ADDR_W  fetch address (= pc_o while requesting).
- imem_ack_i  in  1  fetch complete, one-cycle pulse.
- inst_valid_o  out  1  one-cycle pulse: fetch for inst_pc_o done and not squashed.
- inst_pc_o  out  ADDR_W  PC of the delivered fetch.
- fault_o  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (rst_i=0, async): pc_o=RESET_PC, state BOOT, imem_req_o=0, inst_valid_o=0, inst_pc_o=0, fault_o=0, wait counter=0, redirect-pending=0. step_o is constant STEP at all times.
- States: BOOT, REQ, STALL, FAULT.
- BOOT: one idle cycle after reset release -> REQ.
- REQ: imem_req_o=1, imem_addr_o=pc_o. Wait counter increments each cycle without ack.
  - On ack, no pending redirect, no redirect this cycle:
    - inst_valid_o=1 next cycle with inst_pc_o = fetched PC.
    - If stall_i=0: pc_o<=sum_i, stay REQ (back-to-back; new request the following cycle).
    - If stall_i=1: pc_o<=sum_i, go STALL.
- Redirect next-PC priority: jump_i > branch_taken_i > sum_i.
  - Redirect with ack in same cycle: pc_o<=target; fetched instruction squashed (no inst_valid_o).
  - Redirect while waiting (no ack): target latched into pending register; on ack, pc_o<=pending target, fetch squashed, pending cleared.
  - Newer redirect overwrites pending.
- STALL: imem_req_o=0, pc_o held. Redirect in STALL updates pc_o immediately. stall_i=0 -> REQ.
- Timeout: counter reaching MAX_WAIT without ack -> FAULT. fault_o=1, imem_req_o=0; only reset exits.
- Counter clears on every ack and on entering REQ from STALL.
- Arithmetic: PC wraps modulo 2^ADDR_W via adder (32'hFFFF_FFFC+4 -> 0); no overflow detection.
- Ack outside REQ is ignored.
- Reset mid-fetch aborts immediately; no inst_valid_o for the aborted fetch.

Optional Feature:
- Macro: PC_FETCH_CNT_EN.
- Defined: adds output fetch_cnt_o [31:0].
  - Counts inst_valid_o pulses; reset to 0; wraps at 2^32.
  - Squashed fetches not counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, imem_ack_i every cycle after first req, sum_i modelled as pc_o+4 -> imem_addr_o 0,4,8,12; inst_valid_o pulses with inst_pc_o 0,4,8.
- jump_i=1 target 0x100 and branch_taken_i=1 target 0x200 same cycle as ack -> next pc_o=0x100, no inst_valid_o for that fetch.
- branch_taken_i target 0x40 pulsed 2 cycles before delayed ack -> on ack pc_o=0x40, fetch squashed, next req addr 0x40.
- stall_i held 3 cycles after ack at PC 0x8 -> pc_o=0xC, imem_req_o=0 during stall; resumes req 0xC after release.
- No ack for MAX_WAIT=15 cycles -> fault_o=1, imem_req_o=0 until rst_i low.
- RESET_PC=32'hFFFF_FFFC, one ack -> pc_o wraps to 0x0; rst_i asserted mid-wait -> pc_o=RESET_PC immediately.
